// File: rtl/window_pkg.sv
// window_pkg: shared state encoding, Hamming coefficient table and width helpers.
package window_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;
  // (0.54 + 0.46*cos(2*pi*(i+0.5)/8)) * 100, truncated
  localparam logic [7:0] HAMMING8 [8] = '{8'd96, 8'd71, 8'd36, 8'd11, 8'd11, 8'd36, 8'd71, 8'd96};
  function automatic int prod_w(input int dw, input int cw);
    return dw + cw;
  endfunction
endpackage

// File: rtl/window_seq_if.sv
// window_seq_if: config, control and sample/product stream signals of window_seq.
interface window_seq_if #(
  parameter int SIZE = 8,
  parameter int DW   = 8,
  parameter int CW   = 8
);
  localparam int AW = $clog2(SIZE);
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW+CW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          frame_done;
  modport master (
    output cfg_we, cfg_addr, cfg_data, start, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, busy, frame_done
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, busy, frame_done
  );
endinterface

// File: rtl/window_coef_bank.sv
// window_coef_bank: SIZE x CW coefficient register file, sync write, comb read, sync clear.
module window_coef_bank #(
  parameter int SIZE = 8,
  parameter int CW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [$clog2(SIZE)-1:0] waddr,
  input  logic [CW-1:0]           wdata,
  input  logic [$clog2(SIZE)-1:0] raddr,
  output logic [CW-1:0]           rdata
);
  logic [CW-1:0] mem [SIZE];
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i < SIZE; i++) mem[i] <= '0;
    else if (we)
      mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/window_seq.sv
// window_seq: handshaked frame sequencer applying a per-index coefficient to each sample.
module window_seq
  import window_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int DW   = 8,
  parameter int CW   = 8
) (
  input logic        clk,
  input logic        rst_n,
  window_seq_if.slave bus
);
  localparam int AW = $clog2(SIZE);
  localparam int PW = prod_w(DW, CW);
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);
  state_e        state, state_nxt;
  logic [AW-1:0] idx;
  logic [CW-1:0] coef_rd;
  logic          in_hs, out_hs;
  assign bus.s_ready = state == RUN && (!bus.m_valid || bus.m_ready);
  assign bus.busy    = state != IDLE;
  assign in_hs       = bus.s_valid && bus.s_ready;
  assign out_hs      = bus.m_valid && bus.m_ready;
  // bank is only writable between frames so a running frame sees a stable table
  window_coef_bank #(.SIZE(SIZE), .CW(CW)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.cfg_we && state == IDLE),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (idx),
    .rdata (coef_rd)
  );
  always_comb
    state_nxt = state == IDLE ? (bus.start ? RUN : IDLE)
              : state == RUN  ? (in_hs && idx == LAST ? DRAIN : RUN)
              : (out_hs && bus.m_last ? IDLE : DRAIN);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      bus.m_valid    <= 1'b0;
      bus.m_last     <= 1'b0;
      bus.m_data     <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.frame_done <= state == DRAIN && out_hs && bus.m_last;
      if (state == IDLE && bus.start) idx <= '0;
      if (in_hs) begin
        bus.m_data  <= {{CW{1'b0}}, bus.s_data} * {{DW{1'b0}}, coef_rd};
        bus.m_valid <= 1'b1;
        bus.m_last  <= idx == LAST;
        idx         <= idx == LAST ? idx : idx + 1'b1;
      end else if (out_hs)
        bus.m_valid <= 1'b0;
    end
  logic unused_pw;
  assign unused_pw = PW == DW + CW;
endmodule

// File: doc/window_seq.md
# window_seq

Frame sequencer for the windowing datapath: streams one frame of `SIZE` samples through a per-index coefficient multiply. The coefficient bank is loaded over a config port, normally with the Hamming table scaled ×100. Sits between the sample source and the transform stage and replaces the flat combinational window with a handshaked, one-sample-per-cycle pipeline with frame boundaries.

## Interface
- `SIZE`, 8: samples per frame; ≥2, power of two.
- `DW`, 8: sample width, unsigned.
- `CW`, 8: coefficient width, unsigned, scaled ×100.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cfg_we` in 1: coefficient write strobe.
- `cfg_addr` in $clog2(SIZE): coefficient index.
- `cfg_data` in CW: coefficient value.
- `start` in 1: begin a frame; one-cycle pulse.
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in DW: input sample stream.
- `m_valid` out 1 / `m_ready` in 1 / `m_data` out DW+CW / `m_last` out 1: windowed output stream.
- `busy` out 1: high whenever state ≠ IDLE.
- `frame_done` out 1: one-cycle pulse when a frame is complete.

## Operation
- States are IDLE, RUN and DRAIN.
- **IDLE.**
  - `cfg_we` writes `coef[cfg_addr] <= cfg_data`.
  - `start` sets `idx <= 0` and moves to RUN.
  - `s_ready` = 0.
- **RUN.**
  - `s_ready = !m_valid || m_ready`.
  - On an input handshake: `m_data <= s_data * coef[idx]` (full DW+CW product, no rounding or truncation), `m_valid <= 1`, `m_last <= (idx == SIZE-1)`, then `idx++`.
  - The handshake with `idx == SIZE-1` moves to DRAIN.
- **DRAIN.**
  - `s_ready` = 0.
  - When the last beat completes its output handshake (`m_valid & m_ready & m_last`), pulse `frame_done` on the next cycle and go to IDLE.
- **Output register.** An output handshake without a new input clears `m_valid`. Input and output handshakes in the same cycle keep `m_valid` = 1 and load the new product.
- **Ignored events.**
  - `cfg_we` while `busy`: ignored, bank unchanged.
  - `start` while `busy`: ignored.
  - `s_valid` in IDLE or DRAIN: not consumed.
- **Reset values.** `s_ready`, `m_valid`, `m_last`, `busy` and `frame_done` = 0; `m_data` = 0; `idx` = 0; state = IDLE; all `coef` entries = 0.
- **Reset mid-frame.** The frame is abandoned with no `frame_done`; the next frame requires coefficients to be reloaded.

## Timing
- Latency is one cycle from input handshake to `m_valid`.
- Throughput is one sample per cycle while `m_ready` = 1.
- With `m_ready` held at 1, a frame needs SIZE input cycles plus one.
- Under backpressure (`m_valid` & `!m_ready`):
  - `m_data` and `m_last` are held stable.
  - `s_ready` = 0, so no sample is lost or duplicated.
- `frame_done` goes high exactly one cycle after the last output handshake.
- `start` in the same cycle as `frame_done` is accepted: `busy` is already 0.
- A `start` in the IDLE cycle gives `busy` = 1 on the next cycle.
- A config write is visible to a frame started on the following cycle.
- `idx` never wraps mid-frame. It saturates at SIZE-1 and is reset to 0 only by `start` or reset.

## Structure
- Package `window_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the `HAMMING8` constant array {96,71,36,11,11,36,71,96}, from (0.54 + 0.46·cos(2π(i+0.5)/8))·100 truncated;
  - localparam helpers for the product width.
- Sub-module `window_coef_bank` is a SIZE×CW register file with one synchronous write port, one combinational read port and synchronous clear.
- FSM, index counter and output register live in `window_seq`.

## Test plan
- **Hamming frame.** Load `HAMMING8`, `start`, feed 8 samples of value 1 with `m_ready` = 1 → `m_data` = 96,71,36,11,11,36,71,96; `m_last` only on the 8th beat; `frame_done` one cycle after the 8th output handshake.
- **Max product.** `coef[3]` = 255 and sample 255 at index 3 → `m_data` = 65025, with no overflow.
- **Backpressure.**
  - Stimulus: drop `m_ready` for 5 cycles after beat 2, then toggle it on alternate cycles.
  - Required: `m_data` and `m_last` held while stalled, `s_ready` = 0 while stalled, all 8 products correct and in order.
- **Ignored while busy.** Assert `cfg_we` (addr 0, data 0) and `start` mid-frame → frame output is unchanged and `coef[0]` still reads 96 on the next frame.
- **Reset mid-frame.** Reset after beat 4 → all outputs are 0 the next cycle; no `frame_done`; with no reload, a new frame gives all outputs 0.
- **Back-to-back frames.** `start` in the `frame_done` cycle → the second frame starts with no bubble and matches the first.
